amba_ahb_arbiter: RTL and testbench
===================================

AMBA_AHB_ARBITER -- requirements
Module: amba_ahb_arbiter

Interface
REQ-001 The block SHALL have one clock, hclk, and a synchronous active-low reset, hresetn; all state SHALL update on the rising edge of hclk.
REQ-002 Parameter NM, default 4, SHALL set the number of masters (2..16).
REQ-003 Parameter MW, default 2, SHALL set the hmaster width and SHALL equal clog2(NM).
REQ-004 hclk  in  1  bus clock.
REQ-005 hresetn  in  1  synchronous active-low reset.
REQ-006 hbusreq  in  NM  per-master bus request.
REQ-007 hlock  in  NM  per-master locked-transfer request.
REQ-008 htrans  in  2  muxed owner transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 hburst  in  3  muxed owner burst type: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
REQ-010 hready  in  1  slave ready (transfer accepted).
REQ-011 hgrant  out  NM  one-hot registered grant.
REQ-012 hmaster  out  MW  index of the address-bus owner.
REQ-013 hmastlock  out  1  current owner transfer is locked.

Function
REQ-014 hgrant SHALL be one-hot at all times; with no requester it SHALL select master 0 (default master).
REQ-015 A beat counter SHALL track remaining beats; on an hready=1 edge, next_left SHALL be computed as follows.
- NONSEQ: len-1, where len is 4/8/16 for fixed bursts and 1 for SINGLE/INCR.
- SEQ with left>0: left-1.
- IDLE: 0 (early burst termination).
- BUSY: left (hold).
REQ-016 When hready=0 the counter, hgrant and hmaster SHALL all hold.
REQ-017 An arbitration point SHALL occur on an edge where hready=1, next_left==0, and no lock hold is active.
REQ-018 At an arbitration point the winner SHALL be the first asserted hbusreq scanning indices g+1, g+2, ... g+NM (mod NM), where g is the currently granted index. The current master SHALL therefore keep the grant only when it is the sole requester.
REQ-019 At an arbitration point with no requester, hgrant SHALL move to master 0.
REQ-020 hgrant SHALL change only at arbitration points; the new value SHALL be visible in the cycle after the edge.
REQ-021 hmaster SHALL load the index of hgrant on every hready=1 edge, giving the standard one-hready handover lag behind hgrant.
REQ-022 Deasserting hbusreq mid fixed-length burst SHALL NOT remove the grant before the counter reaches 0.
REQ-023 An INCR (undefined-length) burst SHALL be re-arbitrable on every accepted beat.
REQ-024 The state machine SHALL have three states.
- IDLE: no requests, default grant.
- BURST: left>0.
- LOCKED: lock hold.
REQ-025 State transitions SHALL occur only on hready=1 edges.

Reset
REQ-026 While hresetn=0 at an hclk edge, the outputs SHALL reset to hgrant=1 (master 0), hmaster=0 and hmastlock=0.
REQ-027 While hresetn=0 at an hclk edge, internal state SHALL reset to counter=0, state=IDLE, g=0.
REQ-028 A reset asserted mid-burst SHALL abort the burst immediately, with no completion of remaining beats.
REQ-029 Reset SHALL have priority over hready.

Configuration
REQ-030 With macro AMBA_AHB_ARB_LOCK_EN defined, the locked-transfer behaviour SHALL apply.
- Lock hold SHALL be active while the granted master asserts hlock, and SHALL suppress arbitration points.
- hmastlock SHALL load hlock[granted index] on every hready=1 edge, together with hmaster.
- Lock hold SHALL end on the first hready=1 edge after hlock deasserts with next_left==0.
REQ-031 Without AMBA_AHB_ARB_LOCK_EN, hlock SHALL be ignored, hmastlock SHALL be constant 0, and the LOCKED state SHALL be absent.

Verification (NM=4)
REQ-032 Reset, then idle with hbusreq=0000 -> hgrant=0001, hmaster=0, hmastlock=0.
REQ-033 Masters 1 and 2 request continuously with SINGLE NONSEQ and hready=1 -> grant order 1,2,1,2; hmaster follows one hready edge later.
REQ-034 Master 3 runs INCR4 (NONSEQ+3 SEQ) while master 1 requests; hready is low for 2 cycles on beat 2 -> grant stays 3 until the 4th beat is accepted, then hgrant=0010.
REQ-035 Master 2 runs INCR8 and drives IDLE after 3 beats -> rearbitration on that edge with left forced to 0.
REQ-036 With AMBA_AHB_ARB_LOCK_EN: master 1 holds hlock for three SINGLE transfers while master 0 requests -> grant stays 1 and hmastlock=1 for three beats, then the grant passes to master 0.
REQ-037 hresetn pulsed low during beat 5 of an INCR16 -> next cycle hgrant=0001, hmaster=0, counter=0.

Source files
------------

// File: rtl/amba_ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst-length tracking and hready-qualified handover.
// Define AMBA_AHB_ARB_LOCK_EN to enable locked-transfer hold and hmastlock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no fixed-length burst in flight; arbitration open (master 0 when nobody requests)
// BURST   | beats still outstanding (left > 0)
// LOCKED  | granted master holds hlock; arbitration suppressed
module amba_ahb_arbiter #(
    parameter int NM = 4,
    parameter int MW = 2
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [NM-1:0] hbusreq,
    input  logic [NM-1:0] hlock,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hburst,
    input  logic          hready,
    output logic [NM-1:0] hgrant,
    output logic [MW-1:0] hmaster,
    output logic          hmastlock
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

`ifdef AMBA_AHB_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [3:0]      left_q, left_d;
    logic [MW-1:0]   g_q, g_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [MW-1:0]   master_q, master_d;
    logic            mastlock_q, mastlock_d;

    logic [3:0]      next_left;
    logic            lock_hold;
    logic            arb_point;
    logic            win_found;
    logic [MW-1:0]   win_idx;

    function automatic logic [3:0] burst_last(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: return 4'd3;
            3'd4, 3'd5: return 4'd7;
            3'd6, 3'd7: return 4'd15;
            default:    return 4'd0;
        endcase
    endfunction

`ifdef AMBA_AHB_ARB_LOCK_EN
    assign lock_hold = hlock[g_q];
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign lock_hold    = 1'b0;
`endif

    // BURST is entered exactly when the counter is non-zero, so it doubles as the left>0 test.
    always_comb begin
        next_left = '0;
        case (htrans)
            TR_NONSEQ: next_left = burst_last(hburst);
            TR_SEQ:    next_left = (state_q == ST_BURST) ? left_q - 4'd1 : 4'd0;
            TR_BUSY:   next_left = left_q;
            TR_IDLE:   next_left = '0;
            default:   next_left = '0;
        endcase
    end

    assign arb_point = hready & (next_left == 4'd0) & ~lock_hold;

    // Round-robin scan starting just after the current owner; the owner itself is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NM; i++) begin
            if (!win_found && hbusreq[MW'((int'(g_q) + i) % NM)]) begin
                win_found = 1'b1;
                win_idx   = MW'((int'(g_q) + i) % NM);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        g_d        = g_q;
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;

        if (hready) begin
            left_d     = next_left;
            master_d   = g_q;
            mastlock_d = lock_hold;

            if (arb_point) begin
                g_d     = win_found ? win_idx : '0;
                grant_d = NM'(1) << g_d;
            end

            if (next_left != 4'd0) begin
                state_d = ST_BURST;
`ifdef AMBA_AHB_ARB_LOCK_EN
            end else if (lock_hold) begin
                state_d = ST_LOCKED;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            left_q     <= '0;
            g_q        <= '0;
            grant_q    <= NM'(1);
            master_q   <= '0;
            mastlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            g_q        <= g_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = master_q;
    assign hmastlock = mastlock_q;

endmodule

// File: tb/tb_amba_ahb_arbiter.sv
// Self-checking bench for amba_ahb_arbiter: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_amba_ahb_arbiter;

    localparam int NM = 4;
    localparam int MW = 2;
`ifdef AMBA_AHB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic [NM-1:0] hbusreq;
    logic [NM-1:0] hlock;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hready;
    logic [NM-1:0] hgrant;
    logic [MW-1:0] hmaster;
    logic          hmastlock;

    always #5 hclk = ~hclk;

    amba_ahb_arbiter #(.NM(NM), .MW(MW)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hbusreq  (hbusreq),
        .hlock    (hlock),
        .htrans   (htrans),
        .hburst   (hburst),
        .hready   (hready),
        .hgrant   (hgrant),
        .hmaster  (hmaster),
        .hmastlock(hmastlock)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: owner index, beats remaining, lagged master and lock flag.
    int m_g = 0;
    int m_left = 0;
    int m_master = 0;
    bit m_lock = 1'b0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int burst_beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    always @(posedge hclk) begin : model
        int nl;
        int best;
        int best_d;
        int d;
        bit lk;
        if (!hresetn) begin
            m_g      = 0;
            m_left   = 0;
            m_master = 0;
            m_lock   = 1'b0;
            chk_en   = 1'b1;
        end else if (hready) begin
            case (htrans)
                2'd2:    nl = burst_beats(hburst) - 1;
                2'd3:    nl = (m_left > 0) ? m_left - 1 : 0;
                2'd1:    nl = m_left;
                default: nl = 0;
            endcase
            lk       = LOCK_EN && hlock[m_g];
            m_master = m_g;
            m_lock   = lk;
            if (nl == 0 && !lk) begin
                best   = 0;
                best_d = NM;
                for (int k = 0; k < NM; k++) begin
                    if (hbusreq[k]) begin
                        d = (k - m_g - 1 + 2 * NM) % NM;
                        if (d < best_d) begin
                            best_d = d;
                            best   = k;
                        end
                    end
                end
                m_g = best;
            end
            m_left = nl;
        end
    end

    always @(negedge hclk) begin
        if (chk_en) begin
            check("model_hgrant", 32'(hgrant), 32'(1 << m_g));
            check("model_hmaster", 32'(hmaster), 32'(m_master));
            check("model_hmastlock", 32'(hmastlock), 32'(m_lock));
        end
    end

    task automatic cyc(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
        hbusreq = req;
        hlock   = lk;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g [4];
        logic [1:0] exp_m [4];
        hresetn = 1'b0;
        hbusreq = '0;
        hlock   = '0;
        htrans  = IDLE;
        hburst  = '0;
        hready  = 1'b1;

        // reset and default master
        cyc(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);
        cyc(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);
        check("rst_hgrant", 32'(hgrant), 32'h1);
        check("rst_hmaster", 32'(hmaster), 32'h0);
        check("rst_hmastlock", 32'(hmastlock), 32'h0);
        hresetn = 1'b1;
        cyc(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);
        check("idle_hgrant", 32'(hgrant), 32'h1);
        check("idle_hmaster", 32'(hmaster), 32'h0);

        // masters 1 and 2 alternate on SINGLE transfers, hmaster lags one edge
        exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        exp_m = '{2'd0, 2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0110, 4'b0000, NSEQ, 3'd0, 1'b1);
            check("rr_hgrant", 32'(hgrant), 32'(exp_g[i]));
            check("rr_hmaster", 32'(hmaster), 32'(exp_m[i]));
        end

        // master 3 INCR4 with two wait states on beat 2, master 1 waiting
        cyc(4'b1000, 4'b0000, IDLE, 3'd0, 1'b1);
        check("incr4_take", 32'(hgrant), 32'h8);
        cyc(4'b1010, 4'b0000, NSEQ, 3'd3, 1'b1);
        check("incr4_b1", 32'(hgrant), 32'h8);
        check("incr4_b1_master", 32'(hmaster), 32'h3);
        cyc(4'b1010, 4'b0000, SEQ, 3'd3, 1'b0);
        cyc(4'b1010, 4'b0000, SEQ, 3'd3, 1'b0);
        check("incr4_wait", 32'(hgrant), 32'h8);
        cyc(4'b1010, 4'b0000, SEQ, 3'd3, 1'b1);
        cyc(4'b1010, 4'b0000, SEQ, 3'd3, 1'b1);
        check("incr4_b3", 32'(hgrant), 32'h8);
        cyc(4'b1010, 4'b0000, SEQ, 3'd3, 1'b1);
        check("incr4_handover", 32'(hgrant), 32'h2);

        // master 2 INCR8 terminated early with IDLE after three beats
        cyc(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1);
        check("incr8_take", 32'(hgrant), 32'h4);
        cyc(4'b0101, 4'b0000, NSEQ, 3'd5, 1'b1);
        cyc(4'b0101, 4'b0000, SEQ, 3'd5, 1'b1);
        cyc(4'b0101, 4'b0000, SEQ, 3'd5, 1'b1);
        check("incr8_mid", 32'(hgrant), 32'h4);
        cyc(4'b0101, 4'b0000, IDLE, 3'd5, 1'b1);
        check("incr8_early_term", 32'(hgrant), 32'h1);

        // reset during beat 5 of an INCR16 owned by master 3
        cyc(4'b1000, 4'b0000, IDLE, 3'd0, 1'b1);
        check("incr16_take", 32'(hgrant), 32'h8);
        cyc(4'b1000, 4'b0000, NSEQ, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) cyc(4'b1000, 4'b0000, SEQ, 3'd7, 1'b1);
        check("incr16_b4", 32'(hgrant), 32'h8);
        hresetn = 1'b0;
        cyc(4'b1000, 4'b0000, SEQ, 3'd7, 1'b1);
        check("abort_hgrant", 32'(hgrant), 32'h1);
        check("abort_hmaster", 32'(hmaster), 32'h0);
        check("abort_hmastlock", 32'(hmastlock), 32'h0);
        hresetn = 1'b1;
        cyc(4'b0010, 4'b0000, SEQ, 3'd7, 1'b1);
        check("abort_counter_zero", 32'(hgrant), 32'h2);

        // master 1 locks three SINGLE transfers while master 0 requests
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 4'b0010, NSEQ, 3'd0, 1'b1);
            check("lock_hgrant", 32'(hgrant), LOCK_EN ? 32'h2 : 32'h1);
            check("lock_hmastlock", 32'(hmastlock), LOCK_EN ? 32'h1 : 32'h0);
        end
        cyc(4'b0001, 4'b0000, IDLE, 3'd0, 1'b1);
        check("lock_release", 32'(hgrant), 32'h1);
        check("lock_release_ml", 32'(hmastlock), 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            hresetn = ($urandom_range(0, 249) != 0);
            cyc(4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0));
        end
        hresetn = 1'b1;
        cyc(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
